aes192_inv_cipher_core: RTL and testbench

AES192_INV_CIPHER_CORE -- requirements
Module: aes192_inv_cipher_core

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes192_inv_cipher_core_inv_sbox.sv | 28 ++
 rtl/aes192_inv_cipher_core.sv | 115 +++++++++++
 tb/tb_aes192_inv_cipher_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: round count, FSM encoding, GF(2^8) arithmetic and
// the InvShiftRows byte permutation. Byte 0 of a state is bits [127:120],
// with bytes laid out column-major (byte index = 4*column + row).
package aes_pkg;

  localparam int unsigned NR = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add over the bits of b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes192_inv_cipher_core_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine transform followed by
// the multiplicative inverse in GF(2^8), computed as x^254 (0 maps to 0).
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  logic [7:0] aff;
  logic [7:0] pw;
  logic [7:0] acc;

  // Inverse affine, then square-and-multiply chain accumulating x^(2+4+...+128).
  always_comb begin
    aff = {din_i[6:0], din_i[7]}   ^
          {din_i[4:0], din_i[7:5]} ^
          {din_i[1:0], din_i[7:2]} ^ 8'h05;
    pw  = aff;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      pw  = gmul(pw, pw);
      acc = gmul(acc, pw);
    end
    dout_o = acc;
  end

endmodule

// File: rtl/aes192_inv_cipher_core.sv
// Iterative AES-192 inverse cipher: one round per clock, round keys fetched
// combinationally from an external inverse key schedule via key_idx.
module aes192_inv_cipher_core #(
  parameter int unsigned NR = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] round_key,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] added;
  logic [127:0] mixed;

  // Coefficients {0e,0b,0d,09} rotated per output row, applied per column.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign shifted = inv_shift_rows(st_q);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .din_i  (shifted[127 - 8*g -: 8]),
      .dout_o (subbed[127 - 8*g -: 8])
    );
  end

  assign added = subbed ^ round_key;
  assign mixed = inv_mix_columns(added);

  // Next-state and output decode; the last round bypasses InvMixColumns.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    pt_d    = pt_q;
    rnd_d   = rnd_q;
    key_idx = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = ciphertext ^ round_key;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        key_idx = rnd_q;
        busy    = 1'b1;
        if (rnd_q == LAST_ROUND) begin
          pt_d    = added;
          rnd_d   = '0;
          state_d = FIN;
        end else begin
          st_d  = mixed;
          rnd_d = rnd_q + 4'd1;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and round counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
    end
  end

  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes192_inv_cipher_core.sv
// Directed bench for aes192_inv_cipher_core. Supplies round keys from a
// forward AES-192 key expansion and derives golden values with a forward
// cipher model (decrypt(encrypt(p)) must return p).
module tb_aes192_inv_cipher_core;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] round_key;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] rks [2][13];
  int           key_sel;

  aes192_inv_cipher_core #(.NR(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ciphertext (ciphertext),
    .round_key  (round_key),
    .key_idx    (key_idx),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inverse key schedule: key_idx i selects forward round key 12-i.
  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd12) round_key = rks[key_sel][4'd12 - key_idx];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("key_idx_range", 128'(key_idx <= 4'd12), 128'd1);
  end

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m2(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input int ks, input logic [191:0] key);
    logic [31:0] w [52];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = m2(rc);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int r = 0; r < 13; r++) rks[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = pt ^ rks[ks][0];
    for (int rnd = 1; rnd <= 12; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[r[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c + rr] = s[4*((c + rr) % 4) + rr];
      if (rnd < 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
          t[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = t[i];
      r = r ^ rks[ks][rnd];
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt,
                           input bit chk_pt, input logic [127:0] prev_pt, output logic [127:0] got);
    int n;
    start      = 1'b1;
    ciphertext = ct;
    #1;
    chk({tag, "_accept_key_idx"}, 128'(key_idx), 128'd0);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done === 1'b1) break;
      if (n <= 12) begin
        chk({tag, "_key_idx"}, 128'(key_idx), 128'(n));
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        chk({tag, "_hold_prev"}, plaintext, prev_pt);
      end
    end
    chk({tag, "_latency"}, 128'(n), 128'd13);
    chk({tag, "_fin_busy"}, 128'(busy), 128'd0);
    chk({tag, "_fin_key_idx"}, 128'(key_idx), 128'd0);
    if (chk_pt) chk({tag, "_plaintext"}, plaintext, exp_pt);
    got = plaintext;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 128'(done), 128'd0);
    chk({tag, "_idle_key_idx"}, 128'(key_idx), 128'd0);
    if (chk_pt) chk({tag, "_plaintext_held"}, plaintext, exp_pt);
  endtask

  localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] got;
    logic [127:0] p1, p2, c1, c2;
    int           acc_first, acc_second, dpulses;
    int           phase;

    rst_n      = 1'b0;
    start      = 1'b0;
    ciphertext = '0;
    key_sel    = 0;
    build_sbox();
    expand(0, FIPS_KEY);
    expand(1, 192'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_key_idx", 128'(key_idx), 128'd0);
    chk("rst_plaintext", plaintext, 128'd0);

    // FIPS-197 C.2 vector, start on the first edge out of reset
    rst_n = 1'b1;
    run_block("fips", FIPS_CT, FIPS_PT, 1'b1, 128'd0, got);

    // start held high: accepts 14 cycles apart, key_idx sequence never disturbed
    start      = 1'b1;
    ciphertext = FIPS_CT;
    acc_first  = -1;
    acc_second = -1;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      phase = (i - 1) % 14;
      if (key_idx === 4'd1 && busy === 1'b1) begin
        if (acc_first < 0) acc_first = i;
        else if (acc_second < 0) acc_second = i;
      end
      chk("hold_key_idx", 128'(key_idx), (phase < 12) ? 128'(phase + 1) : 128'd0);
      chk("hold_done", 128'(done), 128'(phase == 12));
      if (phase == 12) chk("hold_plaintext", plaintext, FIPS_PT);
      if (i == 28) start = 1'b0;
    end
    chk("hold_first_accept", 128'(acc_first), 128'd1);
    chk("hold_second_accept", 128'(acc_second), 128'd15);

    // Reset during round 6 discards the block
    start      = 1'b1;
    ciphertext = FIPS_CT;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (key_idx === 4'd6) break;
    end
    chk("midrst_reached_round6", 128'(key_idx), 128'd6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_plaintext", plaintext, 128'd0);
    chk("midrst_key_idx", 128'(key_idx), 128'd0);
    rst_n   = 1'b1;
    dpulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dpulses++;
    end
    chk("midrst_no_done", 128'(dpulses), 128'd0);
    run_block("after_rst", FIPS_CT, FIPS_PT, 1'b1, 128'd0, got);

    // Back-to-back blocks with model-derived ciphertexts
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    c1 = encrypt(p1, 0);
    c2 = encrypt(p2, 0);
    run_block("b2b_1", c1, p1, 1'b1, FIPS_PT, got);
    run_block("b2b_2", c2, p2, 1'b1, p1, got);

    // All-zero key, all-zero ciphertext: re-encrypting the result must give 0
    key_sel = 1;
    run_block("zero", 128'd0, 128'd0, 1'b0, p2, got);
    chk("zero_roundtrip", encrypt(got, 1), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
